// File: rtl/rs_decode_delay_line.sv
// Programmable sample delay line: circular buffer with a fixed pointer
// separation equal to the delay currently in force. Output is masked to
// zero until the line has been primed with curDelay enabled samples.
module rs_decode_delay_line #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned DEPTH         = 264,
  parameter int unsigned ADDR_WIDTH    = 9,
  parameter int unsigned DEFAULT_DELAY = 264
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  enable,
  input  logic                  cfgLoad,
  input  logic [ADDR_WIDTH-1:0] delayCfg,
  input  logic [DATA_WIDTH-1:0] dataIn,
  output logic [DATA_WIDTH-1:0] dataOut,
  output logic                  validOut,
  output logic [ADDR_WIDTH-1:0] curDelay
);

  localparam logic [ADDR_WIDTH-1:0] DEPTH_A   = ADDR_WIDTH'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_A    = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [ADDR_WIDTH-1:0] DEF_A     = ADDR_WIDTH'(DEFAULT_DELAY);
  localparam logic [ADDR_WIDTH-1:0] RD_INIT_A = ADDR_WIDTH'(DEPTH - DEFAULT_DELAY);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH-1:0] fillCnt;
  logic [ADDR_WIDTH-1:0] clampedDelay;
  logic                  primed;
  logic                  advance;

  // Pointer increment wrapping DEPTH-1 -> 0
  function automatic logic [ADDR_WIDTH-1:0] bumpPtr(input logic [ADDR_WIDTH-1:0] p);
    return (p == LAST_A) ? '0 : p + ADDR_WIDTH'(1);
  endfunction

  // Requested delay limited to 1..DEPTH
  always_comb begin
    clampedDelay = delayCfg;
    if (delayCfg == '0) begin
      clampedDelay = ADDR_WIDTH'(1);
    end else if (delayCfg > DEPTH_A) begin
      clampedDelay = DEPTH_A;
    end
  end

  // A reconfiguration edge swallows the sample presented with it
  assign advance = enable && !cfgLoad;
  assign primed  = (fillCnt == curDelay);

  // Sample storage; no reset so it maps onto a plain dual-port RAM
  always_ff @(posedge CLK) begin
    if (advance) begin
      mem[wrPtr] <= dataIn;
    end
  end

  // Pointers, fill tracking, delay register and masked registered output
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      wrPtr    <= '0;
      rdPtr    <= RD_INIT_A;
      fillCnt  <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
      curDelay <= DEF_A;
    end else if (cfgLoad) begin
      wrPtr    <= '0;
      rdPtr    <= DEPTH_A - clampedDelay;
      fillCnt  <= '0;
      dataOut  <= '0;
      validOut <= 1'b0;
      curDelay <= clampedDelay;
    end else if (enable) begin
      wrPtr    <= bumpPtr(wrPtr);
      rdPtr    <= bumpPtr(rdPtr);
      if (!primed) begin
        fillCnt <= fillCnt + ADDR_WIDTH'(1);
      end
      // When read and write addresses coincide the read sees the old word
      dataOut  <= primed ? mem[rdPtr] : '0;
      validOut <= primed;
    end
  end

endmodule
